// File: rtl/infra_sensor_pio.sv
// Avalon-MM input PIO for infrared sensors: per-channel synchroniser, debounce
// filter, edge capture with write-1-to-clear and a maskable level interrupt.
module infra_sensor_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10,
    parameter int EDGE_TYPE       = 2,
    parameter int RESET_LEVEL     = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] RST_VAL  = (RESET_LEVEL != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] deb, deb_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edgecapture, irqmask;
    logic [WIDTH-1:0] wr_bits, clr_bits;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign clr_bits     = (wr_en && address == 2'd3) ? wr_bits : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A new level is accepted only after it has differed from the filtered
    // state for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb <= RST_VAL;
            for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else if (DEBOUNCE_CYCLES == 0) begin
            deb <= sync2;
            for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else if (cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        edge_det = deb ^ deb_prev;
        if (EDGE_TYPE == 0)      edge_det = deb & ~deb_prev;
        else if (EDGE_TYPE == 1) edge_det = ~deb & deb_prev;
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next = 32'(deb);
            2'd1:    rd_next = 32'(irqmask);
            2'd3:    rd_next = 32'(edgecapture);
            default: rd_next = '0;
        endcase
    end

    // Set has priority over a simultaneous write-1-to-clear on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev    <= RST_VAL;
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
            readdata    <= '0;
        end else begin
            deb_prev    <= deb;
            if (wr_en && address == 2'd1) irqmask <= wr_bits;
            edgecapture <= (edgecapture & ~clr_bits) | edge_det;
            irq         <= |(edgecapture & irqmask);
            readdata    <= rd_next;
        end
    end

endmodule

// File: tb/tb_infra_sensor_pio.sv
// Scoreboard bench for infra_sensor_pio: four configurations share the bus and
// are checked every cycle against a timestamp-based reference model.
module tb_infra_sensor_pio;

    localparam int NDUT = 4;
    localparam int P_W  [NDUT] = '{4, 4, 8, 3};
    localparam int P_D  [NDUT] = '{1000, 5, 0, 2};
    localparam int P_CW [NDUT] = '{10, 3, 4, 2};
    localparam int P_E  [NDUT] = '{2, 0, 2, 1};
    localparam int P_RL [NDUT] = '{0, 1, 0, 0};

    typedef logic [NDUT-1:0][7:0] inv_t;
    typedef struct packed {
        logic [NDUT-1:0][31:0] rd;
        logic [NDUT-1:0]       irq;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    inv_t                  in_v;
    logic [NDUT-1:0][31:0] rd;
    logic [NDUT-1:0]       irq_v;

    always #5 clk = ~clk;

    infra_sensor_pio #(.WIDTH(P_W[0]), .DEBOUNCE_CYCLES(P_D[0]), .CNT_W(P_CW[0]),
                       .EDGE_TYPE(P_E[0]), .RESET_LEVEL(P_RL[0])) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_v[0][3:0]),
        .readdata(rd[0]), .irq(irq_v[0]));
    infra_sensor_pio #(.WIDTH(P_W[1]), .DEBOUNCE_CYCLES(P_D[1]), .CNT_W(P_CW[1]),
                       .EDGE_TYPE(P_E[1]), .RESET_LEVEL(P_RL[1])) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_v[1][3:0]),
        .readdata(rd[1]), .irq(irq_v[1]));
    infra_sensor_pio #(.WIDTH(P_W[2]), .DEBOUNCE_CYCLES(P_D[2]), .CNT_W(P_CW[2]),
                       .EDGE_TYPE(P_E[2]), .RESET_LEVEL(P_RL[2])) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_v[2][7:0]),
        .readdata(rd[2]), .irq(irq_v[2]));
    infra_sensor_pio #(.WIDTH(P_W[3]), .DEBOUNCE_CYCLES(P_D[3]), .CNT_W(P_CW[3]),
                       .EDGE_TYPE(P_E[3]), .RESET_LEVEL(P_RL[3])) dut3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_v[3][2:0]),
        .readdata(rd[3]), .irq(irq_v[3]));

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    // Reference model: a level is accepted once the raw input, seen two cycles
    // late, has held a value different from the filtered one for D edges.
    logic [7:0] m_deb  [NDUT];
    logic [7:0] m_prev [NDUT];
    logic [7:0] m_ec   [NDUT];
    logic [7:0] m_mask [NDUT];
    logic [7:0] m_last [NDUT];
    int         m_since[NDUT][8];
    int         ecount = 0;
    inv_t       pipe[$];

    function automatic logic [7:0] wmask(int d);
        return 8'((1 << P_W[d]) - 1);
    endfunction

    function automatic logic [7:0] rl_pat(int d);
        return (P_RL[d] != 0) ? wmask(d) : 8'h00;
    endfunction

    task automatic model_reset();
        inv_t rl_all;
        for (int d = 0; d < NDUT; d++) begin
            m_deb[d]  = rl_pat(d);
            m_prev[d] = rl_pat(d);
            m_last[d] = rl_pat(d);
            m_ec[d]   = 8'h00;
            m_mask[d] = 8'h00;
            rl_all[d] = rl_pat(d);
            for (int b = 0; b < 8; b++) m_since[d][b] = ecount;
        end
        pipe.delete();
        pipe.push_back(rl_all);
        pipe.push_back(rl_all);
    endtask

    task automatic model_edge();
        exp_t       e;
        inv_t       seen;
        logic [7:0] wm, rise, fall, edges, clr, nd;
        logic       wr;
        e = '0;
        if (!reset_n) begin
            model_reset();
            sb.push_back(e);
            return;
        end
        seen = pipe.pop_front();
        pipe.push_back(in_v);
        ecount++;
        wr = chipselect && !write_n;
        for (int d = 0; d < NDUT; d++) begin
            wm = wmask(d);
            e.irq[d] = |(m_ec[d] & m_mask[d]);
            case (address)
                2'd0:    e.rd[d] = 32'(m_deb[d]);
                2'd1:    e.rd[d] = 32'(m_mask[d]);
                2'd3:    e.rd[d] = 32'(m_ec[d]);
                default: e.rd[d] = 32'h0;
            endcase
            rise  = m_deb[d] & ~m_prev[d];
            fall  = ~m_deb[d] & m_prev[d];
            edges = (P_E[d] == 0) ? rise : (P_E[d] == 1) ? fall : (rise | fall);
            clr   = (wr && address == 2'd3) ? (writedata[7:0] & wm) : 8'h00;
            if (wr && address == 2'd1) m_mask[d] = writedata[7:0] & wm;
            m_ec[d] = ((m_ec[d] & ~clr) | edges) & wm;
            nd = m_deb[d];
            for (int b = 0; b < P_W[d]; b++) begin
                if (seen[d][b] != m_last[d][b]) begin
                    m_last[d][b]  = seen[d][b];
                    m_since[d][b] = ecount;
                end
                if (seen[d][b] != m_deb[d][b] && (ecount - m_since[d][b] + 1) >= P_D[d])
                    nd[b] = seen[d][b];
            end
            m_prev[d] = m_deb[d];
            m_deb[d]  = nd;
        end
        sb.push_back(e);
    endtask

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got 0x%08h expected 0x%08h", name, d, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                for (int d = 0; d < NDUT; d++) begin
                    chk("readdata", d, rd[d], e.rd[d]);
                    chk("irq", d, 32'(irq_v[d]), 32'(e.irq[d]));
                end
            end
        end
    end

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic bus_rand(bit force_w1c);
        address    = 2'($urandom_range(0, 3));
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'b1;
        writedata  = $urandom;
        if (force_w1c) begin
            address    = 2'd3;
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end
    endtask

    task automatic in_rand(int slow0);
        for (int b = 0; b < 8; b++) begin
            if (slow0 != 0 && $urandom_range(0, 599) == 0) in_v[0][b] = ~in_v[0][b];
            if ($urandom_range(0, 7) == 0) in_v[1][b] = ~in_v[1][b];
            if ($urandom_range(0, 2) == 0) in_v[2][b] = ~in_v[2][b];
            if ($urandom_range(0, 2) == 0) in_v[3][b] = ~in_v[3][b];
        end
    endtask

    task automatic run(int n, bit w1c, int slow0);
        for (int i = 0; i < n; i++) begin
            bus_rand(w1c);
            in_rand(slow0);
            step();
        end
    endtask

    initial begin : stim
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_v       = '1;
        model_reset();
        run(6, 1'b0, 0);
        reset_n = 1'b1;
        run(1010, 1'b0, 0);
        in_v[0] = 8'h00;
        run(1010, 1'b0, 0);
        in_v[0][1] = 1'b1;
        run(999, 1'b0, 0);
        in_v[0][1] = 1'b0;
        run(1100, 1'b0, 0);
        in_v[0][1] = 1'b1;
        run(1001, 1'b0, 0);
        in_v[0][1] = 1'b0;
        run(1100, 1'b0, 0);
        in_v[0] = 8'h0F;
        run(500, 1'b0, 0);
        reset_n = 1'b0;
        run(3, 1'b0, 0);
        reset_n = 1'b1;
        run(1100, 1'b0, 0);
        run(200, 1'b1, 0);
        run(2500, 1'b0, 1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        step();
        @(posedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
